// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit memory port.
package lsu_pkg;

   localparam int WORD_W = 16;

   typedef enum logic {
      LSU_BYTE = 1'b0,
      LSU_HALF = 1'b1
   } lsu_size_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD     = 3'd1,
      RD_CAP = 3'd2,
      WR     = 3'd3,
      RESP   = 3'd4
   } lsu_state_e;

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian byte lane handling: load extract with sign/zero extension
// and byte merge into an existing word for read-modify-write stores.
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [WORD_W-1:0] word_i,
   input  logic              lane_i,
   input  logic              size_i,
   input  logic              unsigned_i,
   input  logic [7:0]        wbyte_i,
   output logic [WORD_W-1:0] load_o,
   output logic [WORD_W-1:0] merge_o
);

   logic [7:0] w_byte;

   // NOTE: every output gets a value on every path, so no latch can be inferred.
   always_comb begin
      w_byte = lane_i ? word_i[15:8] : word_i[7:0];
      if (size_i == LSU_HALF) begin
         load_o = word_i;
      end else if (unsigned_i) begin
         load_o = {8'h00, w_byte};
      end else begin
         load_o = {{8{w_byte[7]}}, w_byte};
      end
      merge_o = lane_i ? {wbyte_i, word_i[7:0]} : {word_i[15:8], wbyte_i};
   end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator: byte-addressed byte/halfword requests to a 16-bit
// word-addressed dmem without byte enables (byte stores use read-modify-write).
module lsu_mem_port
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 8192
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_we_i,
   input  logic                req_size_i,
   input  logic                req_unsigned_i,
   input  logic [WORD_W-1:0]   req_addr_i,
   input  logic [WORD_W-1:0]   req_wdata_i,
   output logic                rsp_valid_o,
   output logic [WORD_W-1:0]   rsp_rdata_o,
   output logic                rsp_err_o,
   output logic [WORD_W-1:0]   dmem_addr_o,
   output logic [WORD_W-1:0]   dmem_wdata_o,
   output logic                dmem_we_o,
   output logic                dmem_re_o,
   input  logic [WORD_W-1:0]   dmem_rdata_i
);

   lsu_state_e        r_state;
   lsu_state_e        w_next;
   logic              r_we;
   lsu_size_e         r_size;
   logic              r_unsigned;
   logic [WORD_W-1:0] r_addr;
   logic [WORD_W-1:0] r_wdata;
   logic [WORD_W-1:0] r_word;
   logic              r_err;

   logic              w_accept;
   logic              w_bad;
   logic              w_re;
   logic              w_we;
   logic              w_rsp;
   logic [WORD_W-1:0] w_load;
   logic [WORD_W-1:0] w_merge;

   assign w_accept = (r_state == IDLE) && req_valid_i;
   assign w_bad    = (req_size_i && req_addr_i[0]) ||
                     (32'(req_addr_i[15:1]) >= MEM_WORDS);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (req_valid_i) begin
               if (w_bad)                       w_next = RESP;
               else if (req_we_i && req_size_i) w_next = WR;
               else                             w_next = RD;
            end
         end
         RD:      w_next = RD_CAP;
         RD_CAP:  w_next = r_we ? WR : RESP;
         WR:      w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_we       <= 1'b0;
         r_size     <= LSU_BYTE;
         r_unsigned <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_word     <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_we       <= req_we_i;
            r_size     <= lsu_size_e'(req_size_i);
            r_unsigned <= req_unsigned_i;
            r_addr     <= req_addr_i;
            r_wdata    <= req_wdata_i;
            r_word     <= '0;
            r_err      <= w_bad;
         end
         if (r_state == RD_CAP) begin
            r_word <= r_we ? w_merge : w_load;
         end
      end
   end

   lsu_byte_lane u_lane (
      .word_i     (dmem_rdata_i),
      .lane_i     (r_addr[0]),
      .size_i     (r_size),
      .unsigned_i (r_unsigned),
      .wbyte_i    (r_wdata[7:0]),
      .load_o     (w_load),
      .merge_o    (w_merge)
   );

   // Outputs are qualified by rst_n so everything is quiet while reset is held,
   // even before the first reset edge has cleared the state register.
   assign w_re = rst_n && (r_state == RD);
   assign w_we = rst_n && (r_state == WR);
   assign w_rsp = rst_n && (r_state == RESP);

   assign req_ready_o  = rst_n && (r_state == IDLE);
   assign dmem_re_o    = w_re;
   assign dmem_we_o    = w_we;
   assign dmem_addr_o  = (w_re || w_we) ? {1'b0, r_addr[15:1]} : '0;
   assign dmem_wdata_o = w_we ? ((r_size == LSU_HALF) ? r_wdata : r_word) : '0;
   assign rsp_valid_o  = w_rsp;
   assign rsp_err_o    = w_rsp && r_err;
   assign rsp_rdata_o  = (w_rsp && !r_err && !r_we) ? r_word : '0;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: byte-addressed reference memory,
// per-cycle strobe/latency checks, directed cases and randomized traffic.
module tb_lsu_mem_port;

   localparam int MEM_WORDS = 8192;
   localparam int MEM_BYTES = 2 * MEM_WORDS;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic        req_size_i;
   logic        req_unsigned_i;
   logic [15:0] req_addr_i;
   logic [15:0] req_wdata_i;
   logic        rsp_valid_o;
   logic [15:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic [15:0] dmem_addr_o;
   logic [15:0] dmem_wdata_o;
   logic        dmem_we_o;
   logic        dmem_re_o;
   logic [15:0] dmem_rdata_i;

   logic        init_mem = 1'b0;
   logic [15:0] dmem [MEM_WORDS];
   logic [15:0] dmem_q = '0;
   logic [7:0]  ref_mem [MEM_BYTES];

   int vecs = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   lsu_mem_port #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we_i),
      .req_size_i     (req_size_i),
      .req_unsigned_i (req_unsigned_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_rdata_o    (rsp_rdata_o),
      .rsp_err_o      (rsp_err_o),
      .dmem_addr_o    (dmem_addr_o),
      .dmem_wdata_o   (dmem_wdata_o),
      .dmem_we_o      (dmem_we_o),
      .dmem_re_o      (dmem_re_o),
      .dmem_rdata_i   (dmem_rdata_i)
   );

   // dmem: one-cycle read latency, no byte enables
   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < MEM_WORDS; i++) dmem[i] <= {ref_mem[2*i+1], ref_mem[2*i]};
      end else if (dmem_we_o) begin
         dmem[dmem_addr_o[12:0]] <= dmem_wdata_o;
      end
      if (dmem_re_o) dmem_q <= dmem[dmem_addr_o[12:0]];
   end
   assign dmem_rdata_i = dmem_q;

   function automatic logic [15:0] ref_load(input int a, input bit half, input bit uns);
      int v;
      if (half) return {ref_mem[a+1], ref_mem[a]};
      v = int'(ref_mem[a]);
      if (!uns && v >= 128) v = v - 256;
      return v[15:0];
   endfunction

   function automatic logic [52:0] all_outs();
      return {req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
              dmem_addr_o, dmem_wdata_o, dmem_we_o, dmem_re_o};
   endfunction

   // One request from accept to response, checking every cycle in between.
   task automatic txn(input bit we, input bit size, input bit uns, input logic [15:0] addr,
                      input logic [15:0] wdata, input bit hold, input logic [15:0] nxt_addr,
                      input string name);
      int          a;
      int          wa;
      int          exp_lat;
      int          k;
      bit          err;
      bit          got;
      bit          exp_re;
      bit          exp_we;
      logic [15:0] exp_rdata;
      logic [15:0] exp_wdata;
      logic [15:0] word_idx;
      logic [34:0] obs;
      logic [34:0] expv;
      a = int'(addr);
      wa = a & ~1;
      word_idx = addr >> 1;
      err = (a >= MEM_BYTES) || (size && addr[0]);
      exp_rdata = 16'h0000;
      exp_wdata = 16'h0000;
      if (!err && !we) exp_rdata = ref_load(a, size, uns);
      if (!err && we) begin
         ref_mem[a] = wdata[7:0];
         if (size) ref_mem[a+1] = wdata[15:8];
         exp_wdata = {ref_mem[wa+1], ref_mem[wa]};
      end
      if (err)            exp_lat = 1;
      else if (we && size) exp_lat = 2;
      else if (!we)       exp_lat = 3;
      else                exp_lat = 4;

      @(negedge clk);
      req_valid_i = 1'b1;
      req_we_i = we;
      req_size_i = size;
      req_unsigned_i = uns;
      req_addr_i = addr;
      req_wdata_i = wdata;
      vecs++;
      if (req_ready_o !== 1'b1) begin
         miscompares++;
         $display("FAIL %s ready_at_accept got=%b want=1", name, req_ready_o);
      end
      @(posedge clk);
      @(negedge clk);
      if (hold) begin
         req_we_i = 1'b0;
         req_size_i = 1'b1;
         req_unsigned_i = 1'b0;
         req_addr_i = nxt_addr;
         req_wdata_i = 16'($urandom);
      end else begin
         req_valid_i = 1'b0;
         req_we_i = 1'($urandom);
         req_addr_i = 16'($urandom);
         req_wdata_i = 16'($urandom);
      end
      got = 1'b0;
      k = 1;
      while (!got && k <= 8) begin
         if (k > 1) @(negedge clk);
         exp_re = !err && !(we && size) && k == 1;
         exp_we = !err && ((we && size && k == 1) || (we && !size && k == 3));
         obs  = {dmem_re_o, dmem_we_o, req_ready_o, dmem_addr_o, dmem_wdata_o};
         expv = {exp_re, exp_we, 1'b0, (exp_re || exp_we) ? word_idx : 16'h0000,
                 exp_we ? exp_wdata : 16'h0000};
         vecs++;
         if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s strobes cyc=%0d got=%h want=%h", name, k, obs, expv);
         end
         vecs++;
         if (rsp_valid_o === 1'b1) begin
            got = 1'b1;
            if (k != exp_lat || rsp_err_o !== err || rsp_rdata_o !== exp_rdata) begin
               miscompares++;
               $display("FAIL %s response got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                        name, k, rsp_err_o, rsp_rdata_o, exp_lat, err, exp_rdata);
            end
         end else if ({rsp_err_o, rsp_rdata_o} !== 17'h0) begin
            miscompares++;
            $display("FAIL %s idle_rsp cyc=%0d got err=%b rdata=%h want 0", name, k, rsp_err_o, rsp_rdata_o);
         end
         k++;
      end
      if (!got) begin
         vecs++;
         miscompares++;
         $display("FAIL %s timeout no rsp_valid within 8 cycles want lat=%0d", name, exp_lat);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      init_mem = 1'b1;
      req_valid_i = 1'b1;
      req_we_i = 1'b1;
      req_size_i = 1'b0;
      req_unsigned_i = 1'b0;
      req_addr_i = 16'h0010;
      req_wdata_i = 16'hA5A5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vecs++;
         if (all_outs() !== 53'h0) begin
            miscompares++;
            $display("FAIL reset_outs got=%h want=0", all_outs());
         end
      end
      @(negedge clk);
      init_mem = 1'b0;
      req_valid_i = 1'b0;
      rst_n = 1'b1;
      #1;
      vecs++;
      if (all_outs() !== {1'b1, 52'h0}) begin
         miscompares++;
         $display("FAIL reset_release got=%h want=%h", all_outs(), {1'b1, 52'h0});
      end
   endtask

   task automatic test_store_load();
      txn(1, 1, 0, 16'h0010, 16'hBEEF, 0, 0, "hstore_10");
      txn(0, 1, 0, 16'h0010, 16'h0000, 0, 0, "hload_10");
      txn(1, 0, 0, 16'h0011, 16'h0042, 0, 0, "bstore_11");
      txn(0, 0, 0, 16'h0010, 16'h0000, 0, 0, "bload_s_10");
      txn(0, 0, 1, 16'h0010, 16'h0000, 0, 0, "bload_u_10");
      txn(0, 0, 0, 16'h0011, 16'h0000, 0, 0, "bload_s_11");
      txn(0, 1, 0, 16'h0010, 16'h0000, 0, 0, "hload_10_merged");
   endtask

   task automatic test_errors();
      txn(0, 1, 0, 16'h0013, 16'h0000, 0, 0, "misaligned_hload");
      txn(1, 1, 0, 16'h0015, 16'h1234, 0, 0, "misaligned_hstore");
      txn(0, 0, 1, 16'h4000, 16'h0000, 0, 0, "range_bload_4000");
      txn(1, 0, 0, 16'h4001, 16'h00AA, 0, 0, "range_bstore_4001");
      txn(0, 1, 0, 16'h3FFE, 16'h0000, 0, 0, "range_hload_3ffe");
      txn(0, 0, 0, 16'h3FFF, 16'h0000, 0, 0, "range_bload_3fff");
   endtask

   task automatic test_reset_mid();
      logic [15:0] orig;
      orig = {ref_mem[16'h21], ref_mem[16'h20]};
      @(negedge clk);
      req_valid_i = 1'b1;
      req_we_i = 1'b1;
      req_size_i = 1'b0;
      req_unsigned_i = 1'b0;
      req_addr_i = 16'h0021;
      req_wdata_i = {8'h00, ~orig[15:8]};
      vecs++;
      if (req_ready_o !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_accept ready got=%b want=1", req_ready_o);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         vecs++;
         if (all_outs() !== 53'h0) begin
            miscompares++;
            $display("FAIL abort_in_reset cyc=%0d got=%h want=0", i, all_outs());
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         vecs++;
         if (all_outs() !== {1'b1, 52'h0}) begin
            miscompares++;
            $display("FAIL abort_after_release cyc=%0d got=%h want=%h", i, all_outs(), {1'b1, 52'h0});
         end
      end
      txn(0, 1, 0, 16'h0020, 16'h0000, 0, 0, "abort_readback");
   endtask

   task automatic test_back_to_back();
      txn(0, 1, 0, 16'h0010, 16'h0000, 1, 16'h0012, "b2b_first");
      txn(0, 1, 0, 16'h0012, 16'h0000, 0, 0, "b2b_second");
   endtask

   task automatic test_random();
      bit          we;
      bit          size;
      bit          uns;
      logic [15:0] addr;
      for (int n = 0; n < 200; n++) begin
         we = 1'($urandom);
         size = 1'($urandom);
         uns = 1'($urandom);
         case ($urandom_range(0, 3))
            0, 1:    addr = 16'($urandom_range(0, 63));
            2:       addr = 16'($urandom_range(16'h3FF0, 16'h400F));
            default: addr = 16'($urandom);
         endcase
         if (size && $urandom_range(0, 3) != 0) addr[0] = 1'b0;
         txn(we, size, uns, addr, 16'($urandom), 1'($urandom), 16'($urandom), "random");
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'($urandom);
      test_reset();
      test_store_load();
      test_errors();
      test_reset_mid();
      test_back_to_back();
      test_random();
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
Load/store initiator between the execute stage and the 16-bit word-addressed data memory (dmem). It turns byte-addressed byte/halfword load and store requests into dmem read/write strobes. dmem has no byte enables, so byte stores use a read-modify-write sequence. The block also performs little-endian lane extraction and sign/zero extension, and flags misaligned or out-of-range accesses.

Parameters:
MEM_WORDS, 8192, number of 16-bit words in dmem; word indices >= MEM_WORDS are out of range.

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
req_valid_i  input  1  request present
req_ready_o  output  1  request accepted when valid && ready
req_we_i  input  1  1 = store, 0 = load
req_size_i  input  1  0 = byte, 1 = halfword
req_unsigned_i  input  1  byte load: 1 = zero-extend, 0 = sign-extend
req_addr_i  input  16  byte address
req_wdata_i  input  16  store data (byte store uses [7:0])
rsp_valid_o  output  1  one-cycle response pulse
rsp_rdata_o  output  16  load result; 0 for stores/errors
rsp_err_o  output  1  misaligned or out-of-range
dmem_addr_o  output  16  word index = {1'b0, addr[15:1]}
dmem_wdata_o  output  16  write data
dmem_we_o  output  1  write strobe
dmem_re_o  output  1  read strobe
dmem_rdata_i  input  16  dmem data, valid the cycle after dmem_re_o

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, all request registers cleared.
- While rst_n is low, all outputs are 0, including req_ready_o. In the first cycle after release, req_ready_o = 1.
- FSM states: IDLE, RD, RD_CAP, WR, RESP.
- IDLE: req_ready_o = 1. On accept, latch we/size/unsigned/addr/wdata, then branch:
  - error (size = half and addr[0] = 1, or addr[15:1] >= MEM_WORDS) -> RESP with err = 1, no dmem strobe.
  - halfword store -> WR.
  - any load or byte store -> RD.
- RD: dmem_re_o = 1, dmem_addr_o = word index; go to RD_CAP.
- RD_CAP: capture dmem_rdata_i into the word register.
  - Load: extract the lane, go to RESP.
  - Byte store: merge wdata[7:0] into lane addr[0], go to WR.
- WR: dmem_we_o = 1, dmem_wdata_o = full word (halfword store) or merged word (byte store); go to RESP.
- RESP: rsp_valid_o = 1 for exactly one cycle; return to IDLE. There is no response back-pressure.
- req_ready_o = 0 in every state except IDLE. The earliest next accept is the cycle after RESP.
- Lanes are little-endian: addr[0] = 0 selects [7:0], addr[0] = 1 selects [15:8].
- Byte load result is {8{b[7]}, b} when signed, {8'h00, b} when unsigned. Halfword load returns the word unchanged.
- dmem_re_o and dmem_we_o are never both 1. dmem_addr_o and dmem_wdata_o are 0 when no strobe is active.
- Latency from the accept cycle T to the rsp_valid_o cycle:
  - error: T+1
  - halfword store: T+2
  - load: T+3
  - byte store: T+4
- rsp_rdata_o and rsp_err_o are meaningful only while rsp_valid_o = 1, and are 0 otherwise.
- Reset mid-operation: the sequence aborts. No further strobes, no response. A byte store aborted before WR leaves memory unchanged.
- req_* inputs are ignored outside IDLE. Request data is taken only from the latched copy.

Decomposition:
- lsu_pkg holds:
  - typedef lsu_size_e (LSU_BYTE, LSU_HALF)
  - typedef lsu_state_e (IDLE, RD, RD_CAP, WR, RESP)
  - constant WORD_W = 16
- One sub-module, lsu_byte_lane: purely combinational. It provides the lane extract with sign/zero extend and the lane merge for stores. lsu_mem_port instantiates it once.

Test Plan:
- Halfword store addr 0x0010, data 0xBEEF -> T+1 we = 1, dmem_addr 0x0008, wdata 0xBEEF; T+2 rsp_valid, err = 0. Then halfword load 0x0010 -> T+1 re = 1; T+3 rsp_rdata 0xBEEF.
- Byte store addr 0x0011, data 0x0042 over word 0xBEEF -> re at T+1, we at T+3 with wdata 0x42EF, rsp at T+4. Signed byte load 0x0010 -> 0xFFEF. Unsigned byte load 0x0010 -> 0x00EF. Signed byte load 0x0011 -> 0x0042.
- Halfword load addr 0x0013 -> T+1 rsp_valid, err = 1, rdata 0x0000; no dmem strobe at any time.
- Range check: load addr 0x4000 (word 8192) -> err = 1, no strobe. Load addr 0x3FFE -> dmem_addr 0x1FFF, err = 0.
- Byte store with rst_n low during RD_CAP -> no dmem_we_o, no rsp_valid_o; req_ready_o = 1 the cycle after release; target word reads back unchanged.
- req_valid_i held high with two loads queued -> req_ready_o = 0 from T+1 through RESP; second accept occurs the cycle after the first rsp_valid_o; both results are correct and in order.
